// File: rtl/rs232_pkg.sv
// rs232_pkg: definitions shared by the RS-232 receive and transmit paths.
//   - FSM state encoding for the UART receiver
//   - constant functions that derive the bit period (BIT_CNT) and half bit
//     period (HALF) in clock cycles from CLK_FREQ/BAUD
package rs232_pkg;

  localparam int STATE_W = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  // Clock cycles per bit, truncated (50 MHz / 9600 -> 5208).
  function automatic int calc_bit_cnt(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int calc_half_cnt(input int clk_freq, input int baud);
    return calc_bit_cnt(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/rs232_rx_core.sv
// rs232_rx_core: UART receiver (synchroniser, framing FSM, shift register).
// Ports:
//   clk, rst_n     system clock, synchronous active-low reset
//   rx             asynchronous serial input, idle high
//   rx_byte        received byte (shift register contents)
//   byte_vld       1-cycle strobe, cycle of a good stop-bit sample
//   frame_err      1-cycle strobe, stop bit sampled as 0
//   parity_err     1-cycle strobe, parity mismatch with a good stop bit
//   busy           high in any state other than IDLE
// Optional macro RX_PARITY_EN adds an even-parity bit after the data bits.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge
// START  | timing to mid start bit to reject glitches
// DATA   | sampling DATA_W bits mid-bit, LSB first
// PARITY | sampling the even-parity bit (RX_PARITY_EN only)
// STOP   | sampling the stop bit
// BREAK  | after a framing error, wait for BIT_CNT cycles of idle line
module rs232_rx_core
  import rs232_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_byte,
  output logic              byte_vld,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);

  localparam int BIT_CNT = calc_bit_cnt(CLK_FREQ, BAUD);
  localparam int HALF    = calc_half_cnt(CLK_FREQ, BAUD);
  localparam int CNT_W   = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam int IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  logic               rx_s1_q, rx_s2_q, rx_prev_q;
  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               fall, at_last;
`ifdef RX_PARITY_EN
  logic               par_bad_q, par_bad_d;
`endif

  assign fall    = rx_prev_q & ~rx_s2_q;
  assign at_last = (cnt_q == CNT_LAST);
  assign rx_byte = shift_q;
  assign busy    = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    byte_vld   = 1'b0;
    frame_err  = 1'b0;
    parity_err = 1'b0;
    cnt_d      = at_last ? '0 : cnt_q + CNT_W'(1);
`ifdef RX_PARITY_EN
    par_bad_d  = par_bad_q;
`endif
    case (state_q)
      ST_IDLE: if (fall) state_d = ST_START;
      // Leaving START re-zeroes the counter, so every later sample is mid-bit.
      ST_START: if (cnt_q == CNT_MID) state_d = rx_s2_q ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (at_last) begin
          shift_d = {rx_s2_q, shift_q[DATA_W-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      ST_PARITY: begin
        if (at_last) begin
          par_bad_d = rx_s2_q ^ (^shift_q);
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (at_last) begin
          if (rx_s2_q) begin
`ifdef RX_PARITY_EN
            parity_err = par_bad_q;
            byte_vld   = ~par_bad_q;
`else
            byte_vld   = 1'b1;
`endif
            state_d = ST_IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = ST_BREAK;
          end
        end
      end
      // Counter measures consecutive high cycles; any low restarts it.
      ST_BREAK: begin
        if (!rx_s2_q) cnt_d = '0;
        else if (at_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
`ifdef RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
`ifdef RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

endmodule

// File: rtl/rs232_rx_ram_wr.sv
// rs232_rx_ram_wr: receives UART bytes and writes them sequentially into a
// 2**ADDR_W x DATA_W RAM write port starting at address 0.
// Ports:
//   clk, rst_n    system clock, synchronous active-low reset
//   rs232_rx      asynchronous serial input, idle high
//   clr           pulse: restart address at 0 and clear full
//   ram_wr_en     1-cycle RAM write strobe
//   ram_wr_addr   write address (also the running address counter)
//   ram_wr_data   write data, held between strobes
//   rx_done       1-cycle pulse per validly framed byte
//   frame_err     1-cycle pulse, stop bit sampled as 0
//   parity_err    1-cycle pulse, parity mismatch (always 0 without RX_PARITY_EN)
//   ovf           1-cycle pulse, valid byte dropped because full
//   full          level, set by the write to the last address
//   state_led     high while a frame is in progress
// Optional macro RX_PARITY_EN enables even-parity checking.
module rs232_rx_ram_wr
  import rs232_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rs232_rx,
  input  logic              clr,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              rx_done,
  output logic              frame_err,
  output logic              parity_err,
  output logic              ovf,
  output logic              full,
  output logic              state_led
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  logic [DATA_W-1:0] rx_byte;
  logic              byte_vld, core_frame_err, core_parity_err, busy;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              fe_q, fe_d;
  logic              pe_q, pe_d;
  logic              ovf_q, ovf_d;
  logic              full_q, full_d;

  rs232_rx_core #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .DATA_W   (DATA_W)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rs232_rx),
    .rx_byte    (rx_byte),
    .byte_vld   (byte_vld),
    .frame_err  (core_frame_err),
    .parity_err (core_parity_err),
    .busy       (busy)
  );

  always_comb begin
    wr_en_d = 1'b0;
    done_d  = 1'b0;
    ovf_d   = 1'b0;
    fe_d    = core_frame_err;
    pe_d    = core_parity_err;
    data_d  = data_q;
    addr_d  = addr_q;
    full_d  = full_q;
    if (byte_vld) begin
      done_d = 1'b1;
      if (full_q) begin
        ovf_d = 1'b1;
      end else begin
        wr_en_d = 1'b1;
        data_d  = rx_byte;
      end
    end
    // Address advances the cycle after the strobe; the last address saturates.
    if (wr_en_q) begin
      if (addr_q == ADDR_MAX) full_d = 1'b1;
      else                    addr_d = addr_q + ADDR_W'(1);
    end
    // clr overrides a coincident write's address update and full set.
    if (clr) begin
      addr_d = '0;
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ovf_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      ovf_q   <= ovf_d;
      full_q  <= full_d;
    end
  end

  assign ram_wr_en   = wr_en_q;
  assign ram_wr_addr = addr_q;
  assign ram_wr_data = data_q;
  assign rx_done     = done_q;
  assign frame_err   = fe_q;
  assign parity_err  = pe_q;
  assign ovf         = ovf_q;
  assign full        = full_q;
  assign state_led   = busy;

endmodule
